// File: rtl/bus_fifo_lvl.sv
// Single-clock show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
// Holds exactly 2**depth words; pointers carry an extra wrap bit.

module bus_fifo_lvl #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             FLUSH,
    input  logic             DATA_STROBE,
    input  logic [width-1:0] DATA_IN,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic             DATA_READY,
    output logic [width-1:0] DATA_OUT,
    input  logic             DATA_ACK,
    output logic             ALMOST_EMPTY,
    input  logic [depth:0]   AF_LEVEL,
    input  logic [depth:0]   AE_LEVEL,
    output logic [depth:0]   LEVEL,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    input  logic             CLEAR_ERR
);

    localparam int unsigned Entries = 2 ** depth;
    localparam logic [depth:0] One = {{depth{1'b0}}, 1'b1};

    logic [width-1:0] mem_q [Entries];

    logic [depth:0] wr_ptr_q, wr_ptr_d;
    logic [depth:0] rd_ptr_q, rd_ptr_d;
    logic [depth:0] level_q, level_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    logic empty;
    logic full;
    logic push_ok;
    logic pop_ok;
    logic overflow_set;
    logic underflow_set;

    // Status decode from registered pointers only, so no strobe/ack reaches a flag.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[depth-1:0] == rd_ptr_q[depth-1:0]) &&
                (wr_ptr_q[depth] != rd_ptr_q[depth]);
    end

    // Request acceptance and error detection; FLUSH masks both.
    always_comb begin
        push_ok       = DATA_STROBE && !full && !FLUSH;
        pop_ok        = DATA_ACK && !empty && !FLUSH;
        overflow_set  = DATA_STROBE && full && !FLUSH;
        underflow_set = DATA_ACK && empty && !FLUSH;
    end

    // Next-state for pointers, level counter and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        // Set wins over a same-cycle clear.
        overflow_d  = (overflow_q && !CLEAR_ERR) || overflow_set;
        underflow_d = (underflow_q && !CLEAR_ERR) || underflow_set;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + One;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + One;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + One;
                2'b01:   level_d = level_q - One;
                default: level_d = level_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[depth-1:0]] <= DATA_IN;
        end
    end

    // Show-ahead output and threshold compares on the registered level.
    always_comb begin
        FULL         = full;
        DATA_READY   = !empty;
        DATA_OUT     = empty ? '0 : mem_q[rd_ptr_q[depth-1:0]];
        LEVEL        = level_q;
        ALMOST_FULL  = (level_q >= AF_LEVEL);
        ALMOST_EMPTY = (level_q <= AE_LEVEL);
        OVERFLOW     = overflow_q;
        UNDERFLOW    = underflow_q;
    end

endmodule

// File: doc/bus_fifo_lvl.md
Name: bus_fifo_lvl

Overview:
Parametrised synchronous single-clock FIFO, next generation of the bus-side byte/word FIFO between bus slave logic and streaming consumers (UART, accelerator feed).
- Adds true full-depth storage, an occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Keeps the strobe-in / ready-ack-out handshake and the show-ahead output.

Parameters:
width, 8, data word width in bits (1..64)
depth, 8, log2 of entry count; FIFO holds exactly 2**depth words (depth 1..12)

Ports:
CLK  input  1  clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
FLUSH  input  1  synchronous empty request
DATA_STROBE  input  1  push request
DATA_IN  input  width  push data
FULL  output  1  no free entry
ALMOST_FULL  output  1  LEVEL >= AF_LEVEL
DATA_READY  output  1  at least one entry (not empty)
DATA_OUT  output  width  head entry (show-ahead), 0 when empty
DATA_ACK  input  1  pop request
ALMOST_EMPTY  output  1  LEVEL <= AE_LEVEL
AF_LEVEL  input  depth+1  almost-full threshold, static during operation
AE_LEVEL  input  depth+1  almost-empty threshold, static during operation
LEVEL  output  depth+1  current occupancy 0..2**depth
OVERFLOW  output  1  sticky: push attempted while full
UNDERFLOW  output  1  sticky: pop attempted while empty
CLEAR_ERR  input  1  synchronous clear of OVERFLOW/UNDERFLOW

Behaviour:
Reset and storage:
- Reset (RESET_N low, async): pointers=0, LEVEL=0, OVERFLOW=0, UNDERFLOW=0.
- Resulting outputs after reset: FULL=0, DATA_READY=0, DATA_OUT=0, ALMOST_EMPTY=(AE_LEVEL>=0)=1, ALMOST_FULL=(AF_LEVEL==0).
- Memory contents are not reset.
- Pointers are depth+1 bits wide (wrap bit).
- empty = pointers equal.
- full = low depth bits equal and wrap bits differ.
- All 2**depth entries are usable.

Push and pop:
- Push accepted iff DATA_STROBE=1 and FULL=0. DATA_IN is written at the write pointer, and the pointer increments at the clock edge.
- Pop accepted iff DATA_ACK=1 and DATA_READY=1. The read pointer increments at the clock edge.
- DATA_OUT is combinational from mem[rd_ptr] when not empty, else 0.
- Latency: a word pushed at edge N appears on DATA_OUT and raises DATA_READY after edge N (zero added cycles).

Simultaneous and boundary cases:
- Simultaneous push+pop, not full, not empty: both accepted, LEVEL unchanged.
- Push while empty with pop asserted: pop rejected (empty), push accepted, UNDERFLOW sets.
- Push+pop while full: pop accepted; push rejected (FULL=1 at the edge); OVERFLOW sets.
- LEVEL is a registered counter: +1 on push only, -1 on pop only, unchanged on both or neither. It must always equal wr_ptr - rd_ptr (mod 2**(depth+1)).
- Wrap-around: pointers roll from 2**(depth+1)-1 to 0 with no data corruption.

Flags and flush:
- ALMOST_FULL and ALMOST_EMPTY are combinational compares on the registered LEVEL.
- OVERFLOW/UNDERFLOW set on a rejected request. They stay set until CLEAR_ERR or reset.
- CLEAR_ERR and a new error event in the same cycle: flag ends 1 (set wins).
- FLUSH=1 at an edge: both pointers and LEVEL go to 0. Pushes and pops in that cycle are ignored and raise no error flags. Priority: reset > FLUSH > push/pop.
- Reset asserted mid-operation: immediate return to reset state regardless of CLK. In-flight push is lost.
- No combinational path from DATA_STROBE to FULL, or from DATA_ACK to DATA_READY.

Test Plan:
1. Reset then idle, width=8, depth=3 -> DATA_READY=0, FULL=0, LEVEL=0, DATA_OUT=0x00, ALMOST_EMPTY=1 (AE_LEVEL=1), OVERFLOW=UNDERFLOW=0.
2. Fill, depth=3, AF_LEVEL=6: push 0x10..0x17 on 8 consecutive edges.
   - LEVEL goes 1..8.
   - ALMOST_FULL rises after the 6th push.
   - FULL rises after the 8th push.
   - 9th push 0xFF rejected, OVERFLOW=1, LEVEL stays 8.
3. Drain: pop 8 times -> DATA_OUT sequence 0x10..0x17, DATA_READY falls after the 8th pop, DATA_OUT=0. Extra pop sets UNDERFLOW=1. CLEAR_ERR for one cycle clears both flags.
4. Wrap and concurrency: with LEVEL=4, assert push+pop together for 20 cycles, incrementing data.
   - LEVEL stays 4 throughout.
   - Output order is exactly input order across pointer wrap.
   - When full, push+pop together -> pop accepted, OVERFLOW=1, LEVEL=7.
5. Flush: LEVEL=5, FLUSH=1 with DATA_STROBE=1 and DATA_ACK=1 -> next cycle LEVEL=0, DATA_READY=0, no error flags set. The following push of 0xA5 is read back as 0xA5.
6. Async reset: RESET_N pulsed low between clock edges with LEVEL=3 and OVERFLOW=1 -> outputs return to reset values before the next CLK edge. Normal operation resumes after release.
